// File: rtl/batch_sequencer.sv
// batch_sequencer: address, bank and strobe sequencer for a three-bank batch sample buffer.
//   clk, rst               : clock, synchronous active-high reset
//   in_valid               : accept one input sample this edge
//   wr_en, wr_addr, wr_bank: write strobe, address and bank of the accepted sample
//   rd_addr                : time-reversed read address (DEPTH-1-wr_addr)
//   la_bank, cmp_bank      : lookahead (previous) and compute (before previous) banks
//   rec_clear, batch_done  : first / last sample of a batch
//   dec_stb                : decimated output point, out_valid: compute bank fully written
//   state                  : 0=FILL0, 1=FILL1, 2=RUN
module batch_sequencer #(
   parameter int DEPTH = 220,
   parameter int OSR = 1,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [1:0]    wr_bank,
   output logic [AW-1:0] rd_addr,
   output logic [1:0]    la_bank,
   output logic [1:0]    cmp_bank,
   output logic          rec_clear,
   output logic          batch_done,
   output logic          dec_stb,
   output logic          out_valid,
   output logic [1:0]    state
);
   localparam int OW = OSR > 1 ? $clog2(OSR) : 1;
   typedef enum logic [1:0] {FILL0 = 2'd0, FILL1 = 2'd1, RUN = 2'd2} state_t;
   if (DEPTH < 2 || OSR < 1 || DEPTH % OSR != 0) begin : g_bad_params
      $error("batch_sequencer: DEPTH must be >= 2 and a multiple of OSR");
   end
   state_t        state_q;
   logic [AW-1:0] cnt_q, cnt_d, wr_addr_q, rd_addr_q;
   logic [OW-1:0] osr_q, osr_d;
   logic [1:0]    bank_q, bank_d, wr_bank_q, la_bank_q, cmp_bank_q;
   logic          wr_en_q, rec_clear_q, batch_done_q, dec_stb_q, out_valid_q, wrap;
   // bank_q is the bank of the next sample to arrive; the output banks follow the sample just written
   always_comb begin
      wrap = cnt_q == AW'(DEPTH - 1);
      cnt_d = wrap ? '0 : cnt_q + AW'(1);
      osr_d = (wrap || osr_q == OW'(OSR - 1)) ? '0 : osr_q + OW'(1);
      bank_d = !wrap ? bank_q : (bank_q == 2'd2 ? 2'd0 : bank_q + 2'd1);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FILL0;
         cnt_q <= '0;
         osr_q <= '0;
         bank_q <= 2'd0;
         wr_en_q <= 1'b0;
         wr_addr_q <= '0;
         rd_addr_q <= AW'(DEPTH - 1);
         wr_bank_q <= 2'd0;
         la_bank_q <= 2'd2;
         cmp_bank_q <= 2'd1;
         rec_clear_q <= 1'b0;
         batch_done_q <= 1'b0;
         dec_stb_q <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         wr_en_q <= in_valid;
         rec_clear_q <= in_valid && cnt_q == '0;
         batch_done_q <= in_valid && wrap;
         dec_stb_q <= in_valid && osr_q == OW'(OSR - 1);
         out_valid_q <= in_valid && state_q == RUN;
         if (in_valid) begin
            cnt_q <= cnt_d;
            osr_q <= osr_d;
            bank_q <= bank_d;
            wr_addr_q <= cnt_q;
            rd_addr_q <= AW'(DEPTH - 1) - cnt_q;
            wr_bank_q <= bank_q;
            la_bank_q <= bank_q == 2'd0 ? 2'd2 : bank_q - 2'd1;
            cmp_bank_q <= bank_q == 2'd2 ? 2'd0 : bank_q + 2'd1;
            state_q <= !wrap ? state_q : (state_q == FILL0 ? FILL1 : RUN);
         end
      end
   end
   assign wr_en = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign rd_addr = rd_addr_q;
   assign wr_bank = wr_bank_q;
   assign la_bank = la_bank_q;
   assign cmp_bank = cmp_bank_q;
   assign rec_clear = rec_clear_q;
   assign batch_done = batch_done_q;
   assign dec_stb = dec_stb_q;
   assign out_valid = out_valid_q;
   assign state = state_q;
endmodule

// File: tb/tb_batch_sequencer.sv
// tb_batch_sequencer: checks three batch_sequencer configurations against a sample-index model.
module tb_batch_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   always #5 clk = ~clk;

   logic       a_we, a_rc, a_bd, a_ds, a_ov;
   logic [1:0] a_wa, a_ra, a_wb, a_lb, a_cb, a_st;
   logic       b_we, b_rc, b_bd, b_ds, b_ov;
   logic [1:0] b_wa, b_ra, b_wb, b_lb, b_cb, b_st;
   logic       c_we, c_rc, c_bd, c_ds, c_ov;
   logic [7:0] c_wa, c_ra;
   logic [1:0] c_wb, c_lb, c_cb, c_st;

   batch_sequencer #(.DEPTH(4), .OSR(1)) u_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .wr_en(a_we), .wr_addr(a_wa), .wr_bank(a_wb),
      .rd_addr(a_ra), .la_bank(a_lb), .cmp_bank(a_cb), .rec_clear(a_rc), .batch_done(a_bd),
      .dec_stb(a_ds), .out_valid(a_ov), .state(a_st));
   batch_sequencer #(.DEPTH(4), .OSR(2)) u_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .wr_en(b_we), .wr_addr(b_wa), .wr_bank(b_wb),
      .rd_addr(b_ra), .la_bank(b_lb), .cmp_bank(b_cb), .rec_clear(b_rc), .batch_done(b_bd),
      .dec_stb(b_ds), .out_valid(b_ov), .state(b_st));
   batch_sequencer #(.DEPTH(220), .OSR(1)) u_c (
      .clk(clk), .rst(rst), .in_valid(in_valid), .wr_en(c_we), .wr_addr(c_wa), .wr_bank(c_wb),
      .rd_addr(c_ra), .la_bank(c_lb), .cmp_bank(c_cb), .rec_clear(c_rc), .batch_done(c_bd),
      .dec_stb(c_ds), .out_valid(c_ov), .state(c_st));

   int compared = 0;
   int mismatched = 0;
   int n = 0;
   bit acc = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0d expected=%0d (t=%0t, sample count=%0d)", tag, obs, exp, $time, n);
      end
   endtask

   // Expected outputs follow from the number of samples accepted since reset:
   // sample s sits at s%D in batch s/D, whose bank is (s/D)%3.
   task automatic check_dut(string nm, int d, int o, logic we, logic [31:0] wa, logic [31:0] ra,
                            logic [1:0] wb, logic [1:0] lb, logic [1:0] cb, logic rc, logic bd,
                            logic ds, logic ov, logic [1:0] st);
      int s, pos, b;
      s = n - 1;
      pos = n == 0 ? 0 : s % d;
      b = n == 0 ? 0 : (s / d) % 3;
      chk({nm, ".wr_en"}, 32'(we), 32'(acc));
      chk({nm, ".wr_addr"}, wa, 32'(pos));
      chk({nm, ".rd_addr"}, ra, 32'(d - 1 - pos));
      chk({nm, ".wr_bank"}, 32'(wb), 32'(b));
      chk({nm, ".la_bank"}, 32'(lb), 32'((b + 2) % 3));
      chk({nm, ".cmp_bank"}, 32'(cb), 32'((b + 1) % 3));
      chk({nm, ".rec_clear"}, 32'(rc), 32'(acc && pos == 0));
      chk({nm, ".batch_done"}, 32'(bd), 32'(acc && pos == d - 1));
      chk({nm, ".dec_stb"}, 32'(ds), 32'(acc && pos % o == o - 1));
      chk({nm, ".out_valid"}, 32'(ov), 32'(acc && s >= 2 * d));
      chk({nm, ".state"}, 32'(st), 32'(n / d >= 2 ? 2 : n / d));
   endtask

   task automatic step(bit r, bit v);
      @(negedge clk);
      rst = r;
      in_valid = v;
      @(posedge clk);
      if (r) begin
         n = 0;
         acc = 0;
      end else begin
         acc = v;
         if (v) n++;
      end
      #1;
      check_dut("d4o1", 4, 1, a_we, 32'(a_wa), 32'(a_ra), a_wb, a_lb, a_cb, a_rc, a_bd, a_ds, a_ov, a_st);
      check_dut("d4o2", 4, 2, b_we, 32'(b_wa), 32'(b_ra), b_wb, b_lb, b_cb, b_rc, b_bd, b_ds, b_ov, b_st);
      check_dut("d220", 220, 1, c_we, 32'(c_wa), 32'(c_ra), c_wb, c_lb, c_cb, c_rc, c_bd, c_ds, c_ov, c_st);
   endtask

   initial begin
      step(1, 0);
      step(1, 0);
      step(0, 0);
      for (int i = 0; i < 700; i++) step(0, 1);
      step(0, 0);
      step(1, 0);
      step(0, 1);
      step(0, 0);
      step(0, 0);
      step(0, 1);
      step(1, 1);
      for (int i = 0; i < 10; i++) step(0, 1);
      step(1, 1);
      for (int i = 0; i < 10; i++) step(0, 1);
      for (int i = 0; i < 3000; i++) step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
